// File: rtl/bus_pkg.sv
// Shared defaults and helpers for the OR-bus arbiter.
package bus_pkg;

  localparam int BUS_AW     = 2;
  localparam int BUS_DW     = 4;
  localparam int BUS_MAX_NC = 8;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(
    input logic [BUS_MAX_NC-1:0] v
  );
    return |(v & (v - {{(BUS_MAX_NC-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so ptr lands on bit 0, take the
// lowest set bit, then rotate that one-hot back to client order.
module rr_pick #(
  parameter int NC = 4,
  parameter int PW = $clog2(NC)
) (
  input  logic [NC-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NC-1:0] pick
);

  localparam logic [PW-1:0] LAST = PW'(NC-1);

  logic [2*NC-2:0] req_dbl;
  logic [2*NC-2:0] oh_dbl;
  logic [NC-1:0]   rot;
  logic [NC-1:0]   rot_oh;
  logic [PW-1:0]   back;

  assign req_dbl = {req[NC-2:0], req};
  assign rot     = req_dbl[ptr +: NC];
  assign rot_oh  = rot & (~rot + NC'(1));

  // oh_dbl[j] = rot_oh[(j+1) mod NC]
  assign oh_dbl  = {rot_oh, rot_oh[NC-1:1]};
  assign back    = LAST - ptr;
  assign pick    = oh_dbl[back +: NC];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and registered OR-combiner for the shared bus.
// Define ARB_BURST_LIMIT_EN to cap a holder at MAX_BURST under contention.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NC        = 4,
  parameter int AW        = BUS_AW,
  parameter int DW        = BUS_DW,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NC-1:0]    arb_req,
  output logic [NC-1:0]    arb_grant,
  input  logic [NC-1:0]    br_valid,
  input  logic [NC*AW-1:0] br_addr,
  input  logic [NC*DW-1:0] br_data,
  output logic             bt_valid,
  output logic [AW-1:0]    bt_addr,
  output logic [DW-1:0]    bt_data,
  output logic             err_multi
);

  localparam int PW = $clog2(NC);
  localparam logic [PW-1:0] LAST = PW'(NC-1);

  if (NC < 2 || NC > BUS_MAX_NC || MAX_BURST < 1) begin : g_cfg_err
    $error("bus_arbiter: unsupported NC or MAX_BURST");
  end

  logic [NC-1:0] grant_q;
  logic [NC-1:0] grant_d;
  logic [NC-1:0] pick;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick_idx;
  logic          hold_req;
  logic          keep;
  logic [AW-1:0] addr_or;
  logic [DW-1:0] data_or;

  // Masking with arb_req stops a stale grant from enabling a driver.
  assign arb_grant = grant_q & arb_req;
  assign hold_req  = |arb_grant;

  rr_pick #(.NC(NC), .PW(PW)) u_pick (
    .req  (arb_req),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NC; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] burst_cnt;
  logic          limit;

  // burst_cnt holds completed cycles; this cycle makes it +1.
  assign limit = hold_req &&
                 (int'(burst_cnt) + 1 >= MAX_BURST) &&
                 |(arb_req & ~grant_q);
  assign keep  = hold_req && !limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (!keep) begin
      burst_cnt <= '0;
    end else if (int'(burst_cnt) < MAX_BURST) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end
`else
  assign keep = hold_req;
`endif

  assign grant_d = keep ? grant_q : pick;

  always_comb begin
    addr_or = '0;
    data_or = '0;
    for (int i = 0; i < NC; i++) begin
      addr_or = addr_or | br_addr[i*AW +: AW];
      data_or = data_or | br_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      rr_ptr    <= '0;
      bt_valid  <= 1'b0;
      bt_addr   <= '0;
      bt_data   <= '0;
      err_multi <= 1'b0;
    end else begin
      grant_q <= grant_d;
      if (!keep && |pick) begin
        rr_ptr <= (pick_idx == LAST) ? '0 : pick_idx + PW'(1);
      end
      bt_valid <= |br_valid;
      bt_addr  <= addr_or;
      bt_data  <= data_or;
      if (multi_hot(BUS_MAX_NC'(br_valid))) err_multi <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corners,
// and randomized traffic against a behavioural model.
module tb_bus_arbiter;

  localparam int NC = 4;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int MB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    arb_req;
  logic [NC-1:0]    arb_grant;
  logic [NC-1:0]    br_valid;
  logic [NC*AW-1:0] br_addr;
  logic [NC*DW-1:0] br_data;
  logic             bt_valid;
  logic [AW-1:0]    bt_addr;
  logic [DW-1:0]    bt_data;
  logic             err_multi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NC(NC), .AW(AW), .DW(DW), .MAX_BURST(MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .br_valid  (br_valid),
    .br_addr   (br_addr),
    .br_data   (br_data),
    .bt_valid  (bt_valid),
    .bt_addr   (bt_addr),
    .bt_data   (bt_data),
    .err_multi (err_multi)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  bv;
    logic [7:0]  ba;
    logic [15:0] bd;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  a;
    logic [3:0]  d;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] req, input logic [3:0] bv,
    input logic [7:0] ba, input logic [15:0] bd, input logic [3:0] g,
    input logic v, input logic [1:0] a, input logic [3:0] d,
    input logic e
  );
    vec_t t;
    t.rst = r; t.req = req; t.bv = bv; t.ba = ba; t.bd = bd;
    t.g = g; t.v = v; t.a = a; t.d = d; t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: holder index, scan start, cycles held.
  int         m_hold;
  int         m_ptr;
  int         m_run;
  logic       m_v;
  logic [1:0] m_a;
  logic [3:0] m_d;
  logic       m_e;

  function automatic void m_reset();
    m_hold = -1; m_ptr = 0; m_run = 0;
    m_v = 1'b0; m_a = '0; m_d = '0; m_e = 1'b0;
  endfunction

  function automatic logic [3:0] m_grant(input logic [3:0] req);
    if (m_hold >= 0 && req[m_hold]) return 4'(1 << m_hold);
    return 4'b0;
  endfunction

  function automatic void m_step(input logic [3:0] req,
    input logic [3:0] bv, input logic [7:0] ba, input logic [15:0] bd);
    bit keep;
    bit others;
    bit found;
    int c;
    others = 1'b0;
    for (int i = 0; i < NC; i++)
      if (req[i] && i != m_hold) others = 1'b1;
    keep = (m_hold >= 0) && req[m_hold];
    if (keep) m_run++;
    if (BURST && keep && m_run >= MB && others) keep = 1'b0;
    if (!keep) begin
      m_hold = -1;
      m_run = 0;
      found = 1'b0;
      for (int k = 0; k < NC; k++) begin
        c = (m_ptr + k) % NC;
        if (!found && req[c]) begin
          found = 1'b1;
          m_hold = c;
          m_ptr = (c + 1) % NC;
        end
      end
    end
    m_v = |bv;
    m_a = ba[1:0] | ba[3:2] | ba[5:4] | ba[7:6];
    m_d = bd[3:0] | bd[7:4] | bd[11:8] | bd[15:12];
    if ($countones(bv) > 1) m_e = 1'b1;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] bv,
                       input logic [7:0] ba, input logic [15:0] bd);
    arb_req = req; br_valid = bv; br_addr = ba; br_data = bd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b0, 4'b0, 8'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_reset();
  endtask

  logic [3:0] exp_g;
  logic [3:0] r_req;
  logic [3:0] r_bv;
  logic [7:0] r_ba;
  logic [15:0] r_bd;

  initial begin
    rst = 1'b1;
    drive(4'b0, 4'b0, 8'h0, 16'h0);
    m_reset();
    #3;
    chk("reset_grant", 32'(arb_grant), 32'h0);
    chk("reset_bt_valid", 32'(bt_valid), 32'h0);
    chk("reset_bt_addr", 32'(bt_addr), 32'h0);
    chk("reset_bt_data", 32'(bt_data), 32'h0);
    chk("reset_err", 32'(err_multi), 32'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // single request, stale grant, wrap-around from rr_ptr=3
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 8'h30, 16'h0A00, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 16'h0000, 4'b0000, 1, 3, 4'hA, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 8'h00, 16'h0000, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 8'h00, 16'h0000, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    // simultaneous 1011, each holder drops after one cycle: 0,1,3,0
    tbl.push_back(mk(1, 4'b1011, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b0000, 8'h00, 16'h0000, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b0000, 8'h00, 16'h0000, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 8'h00, 16'h0000, 4'b1000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 8'h00, 16'h0000, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].req, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), 32'(arb_grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_bus", i),
          32'({bt_valid, bt_addr, bt_data, err_multi}),
          32'({tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].e}));
      @(posedge clk); #1;
    end

    // burst: client 0 from cycle 1, client 2 joins at cycle 3
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      drive((c >= 3) ? 4'b0101 : 4'b0001, 4'b0, 8'h0, 16'h0);
      if (c == 1) exp_g = 4'b0000;
      else if (BURST && c >= 6) exp_g = 4'b0100;
      else exp_g = 4'b0001;
      @(negedge clk);
      chk($sformatf("burst_c%0d", c), 32'(arb_grant), 32'(exp_g));
      @(posedge clk); #1;
    end

    // collision is sticky; then async reset mid-cycle
    drive(4'b0101, 4'b0110, 8'h00, 16'h0000);
    @(posedge clk); #1;
    drive(4'b0101, 4'b0000, 8'h00, 16'h0000);
    @(negedge clk);
    chk("coll_err", 32'(err_multi), 32'h1);
    chk("coll_valid", 32'(bt_valid), 32'h1);
    @(posedge clk); #1;
    drive(4'b0101, 4'b0010, 8'h04, 16'h0050);
    @(negedge clk);
    chk("coll_sticky", 32'(err_multi), 32'h1);
    @(posedge clk); #1;
    drive(4'b0101, 4'b0000, 8'h00, 16'h0000);
    @(negedge clk);
    chk("single_bus", 32'({bt_valid, bt_addr, bt_data}), 32'({1'b1, 2'h1, 4'h5}));
    chk("single_err", 32'(err_multi), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", 32'(arb_grant), 32'h0);
    chk("async_bus", 32'({bt_valid, bt_addr, bt_data}), 32'h0);
    chk("async_err", 32'(err_multi), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    do_reset();
    r_req = 4'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) r_req[$urandom_range(0, 3)] ^= 1'b1;
      exp_g = m_grant(r_req);
      r_bv = exp_g;
      if ($urandom_range(0, 199) == 0) r_bv[$urandom_range(0, 3)] = 1'b1;
      r_ba = '0;
      r_bd = '0;
      for (int i = 0; i < NC; i++) begin
        if (r_bv[i]) begin
          r_ba[i*AW +: AW] = 2'($urandom);
          r_bd[i*DW +: DW] = 4'($urandom);
        end
      end
      drive(r_req, r_bv, r_ba, r_bd);
      @(negedge clk);
      chk("rnd_grant", 32'(arb_grant), 32'(exp_g));
      chk("rnd_bus", 32'({bt_valid, bt_addr, bt_data}), 32'({m_v, m_a, m_d}));
      chk("rnd_err", 32'(err_multi), 32'(m_e));
      m_step(r_req, r_bv, r_ba, r_bd);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter and bus combiner for the shared OR-bus. Sits on the other end of each client interface's arb_req/arb_grant handshake.
- Round-robin grants one client at a time.
- OR-combines the clients' driven br_valid/br_addr/br_data and registers the result onto the target-side broadcast bus (bt_valid/bt_addr/bt_data) that every interface's receive side decodes.

Parameters:
- NC, 4, number of clients (2..8)
- AW, 2, address width
- DW, 4, data width
- MAX_BURST, 4, max consecutive granted cycles when another client is waiting (used only with ARB_BURST_LIMIT_EN)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- arb_req  input  NC  per-client request (bit i = client i)
- arb_grant  output  NC  per-client grant, one-hot or zero
- br_valid  input  NC  per-client driven valid
- br_addr  input  NC*AW  per-client driven address, client i at [i*AW +: AW]
- br_data  input  NC*DW  per-client driven data, client i at [i*DW +: DW]
- bt_valid  output  1  registered bus valid to targets
- bt_addr  output  AW  registered bus address
- bt_data  output  DW  registered bus data
- err_multi  output  1  sticky: more than one br_valid seen in one cycle

Behaviour:
- Reset (async, active-high), all to 0: grant_q, rr_ptr, burst_cnt, bt_valid, bt_addr, bt_data, err_multi.
- arb_grant = grant_q & arb_req (combinational AND). This prevents a stale grant making a client drive br_valid after it has dropped its request.
- grant_q register update each clk edge:
  - Holder h (grant_q[h]=1) with arb_req[h]=1 keeps the grant, unless the burst limit applies (see Optional Feature).
  - Otherwise pick the first requester scanning rr_ptr, rr_ptr+1, …, NC-1, 0, …, wrapping modulo NC. grant_q becomes one-hot of that requester, or 0 if there are no requesters.
  - On every new grant to client k: rr_ptr <= (k+1) mod NC.
- Latency:
  - A request raised in cycle t on an idle bus is granted in cycle t+1.
  - A holder dropping its request in cycle t costs one idle cycle (t). The next client is granted in t+1.
- Simultaneous requests: resolved purely by rr_ptr. After reset rr_ptr=0, so client 0 wins.
- Bus combine (combinational OR over all clients of br_valid/br_addr/br_data), registered one stage:
  - bt_valid <= |br_valid
  - bt_addr <= OR of all br_addr slices
  - bt_data <= OR of all br_data slices
  - Bus latency is one cycle, fixed.
- err_multi: set when popcount(br_valid) > 1. It stays set until reset. When err_multi fires, bt_* still carries the raw OR.
- Reset mid-transfer: grant and bus outputs drop to 0 asynchronously. No transfer is replayed.

Optional Feature:
- Macro ARB_BURST_LIMIT_EN.
- Defined:
  - burst_cnt counts consecutive cycles with arb_grant[h]=1.
  - When burst_cnt reaches MAX_BURST and any other client requests, the holder loses grant_q at that edge. The next requester from rr_ptr (= h+1) is granted.
  - burst_cnt clears on any grant change.
  - With no other requester, the holder keeps the grant and burst_cnt saturates.
- Not defined: the holder keeps the grant as long as it requests. burst_cnt logic and the MAX_BURST parameter are unused.

Decomposition:
- Package bus_pkg holds default AW/DW and a function that returns the popcount-greater-than-1 check for err_multi.
- One sub-module, rr_pick: NC-wide requester vector plus rr_ptr in, one-hot pick out. It is purely combinational (double-width rotate and priority scan).

Test Plan:
- Reset then single request: arb_req=4'b0100 from cycle 1 -> arb_grant=4'b0100 from cycle 2. Client drives addr 2'h3, data 4'hA -> bt_valid=1, bt_addr=3, bt_data=A one cycle later.
- Simultaneous requests: arb_req=4'b1011 held continuously, each holder dropping after 1 cycle -> grant order 0,1,3,0 with one idle cycle between grants.
- Wrap-around: rr_ptr=3 (after granting client 2), arb_req=4'b0011 -> client 0 granted, then rr_ptr=1.
- Stale grant: holder drops arb_req mid-cycle -> arb_grant goes 0 the same cycle. No br_valid appears on the next bt_valid.
- Burst limit (ARB_BURST_LIMIT_EN, MAX_BURST=4): client 0 requests continuously, client 2 requests from cycle 3 -> client 0 granted exactly 4 cycles, then client 2. Without the macro, client 0 holds indefinitely.
- Collision and async reset: force br_valid=4'b0110 -> err_multi=1 next cycle and stays set. Assert rst mid-grant -> arb_grant, bt_* and err_multi drop to 0 immediately, without waiting for a clock edge.
